// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver.
// Synchronises the raw PS/2 clock and data lines, deserialises 11-bit
// device-to-host frames (start, 8 data LSB first, odd parity, stop) and
// queues good scan codes in a small FIFO. The consumer pops the head byte
// by holding kbi_rdn low for one cycle.
//
// Receive FSM states:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | bus idle, waiting for a falling edge with data low (start)
//   ST_DATA   | shifting in data bits 0..7, LSB first
//   ST_PARITY | next falling edge carries the odd-parity bit
//   ST_STOP   | next falling edge carries the stop bit; frame is judged
module ps2_keyboard #(
    parameter int FIFO_AW = 2,
    parameter int TIMEOUT = 50000
) (
    input  logic               kbi_clk,
    input  logic               kbi_rst,
    input  logic               kbi_ps2_clk,
    input  logic               kbi_ps2_data,
    input  logic               kbi_rdn,
    output logic               kbo_data_ready,
    output logic [7:0]         kbo_scan_code,
    output logic               kbo_frame_err,
    output logic               kbo_overflow,
    output logic [FIFO_AW:0]   kbo_count
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]      TMO_LIM  = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    rx_state_t state, state_nxt;

    logic clk_s1, clk_s2, clk_s3;
    logic data_s1, data_s2;
    logic fe;
    logic bit_in;

    logic [2:0]  bit_idx;
    logic [7:0]  data_sr;
    logic        parity_bit;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    logic        frame_done;
    logic        frame_good;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               push_req;
    logic               push_ok;
    logic               pop;

    // Two-flop synchronisers; the clock line gets a third flop for edge detect.
    // Flops reset to 1 so an idle-high bus never looks like a falling edge.
    always_ff @(posedge kbi_clk) begin
        if (kbi_rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= kbi_ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= kbi_ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fe     = clk_s3 & ~clk_s2;
    assign bit_in = data_s2;

    // A stalled frame is abandoned once the counter reaches the limit.
    assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TMO_LIM);

    // Receive state register.
    always_ff @(posedge kbi_clk) begin
        if (kbi_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and end-of-frame verdict.
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        frame_good = 1'b0;
        if (tmo_hit) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A high start bit is treated as noise and ignored quietly.
                    if (fe && !bit_in) begin
                        state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (fe && (bit_idx == 3'd7)) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (fe) begin
                        state_nxt = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fe) begin
                        frame_done = 1'b1;
                        frame_good = bit_in && (^{data_sr, parity_bit});
                        state_nxt  = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Shift register, bit index and parity capture.
    always_ff @(posedge kbi_clk) begin
        if (kbi_rst) begin
            bit_idx    <= 3'd0;
            data_sr    <= 8'd0;
            parity_bit <= 1'b0;
        end else if (fe && !tmo_hit) begin
            case (state)
                ST_IDLE: begin
                    bit_idx <= 3'd0;
                end
                ST_DATA: begin
                    data_sr[bit_idx] <= bit_in;
                    bit_idx          <= bit_idx + 3'd1;
                end
                ST_PARITY: begin
                    parity_bit <= bit_in;
                end
                default: ;
            endcase
        end
    end

    // Inactivity counter: cleared while idle and on every PS/2 falling edge.
    always_ff @(posedge kbi_clk) begin
        if (kbi_rst || (state == ST_IDLE) || fe) begin
            tmo_cnt <= 16'd0;
        end else if (tmo_cnt != TMO_LIM) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign push_req = frame_done && frame_good;
    assign pop      = !kbi_rdn && (count != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && ((count != FULL_CNT) || pop);

    // FIFO storage, pointers, occupancy and one-cycle status pulses.
    always_ff @(posedge kbi_clk) begin
        if (kbi_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            kbo_frame_err <= 1'b0;
            kbo_overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data_sr;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            kbo_frame_err <= frame_done && !frame_good;
            kbo_overflow  <= push_req && !push_ok;
        end
    end

    assign kbo_data_ready = (count != '0);
    assign kbo_scan_code  = mem[rd_ptr];
    assign kbo_count      = count;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: frames are bit-banged on the PS/2 pins
// with a slow clock (20 system cycles per half period) and results are
// compared against hand-computed values.
`timescale 1ns/1ps
module tb_ps2_keyboard;

    localparam int FIFO_AW = 2;
    localparam int TMO     = 1000;

    logic             kbi_clk;
    logic             kbi_rst;
    logic             kbi_ps2_clk;
    logic             kbi_ps2_data;
    logic             kbi_rdn;
    logic             kbo_data_ready;
    logic [7:0]       kbo_scan_code;
    logic             kbo_frame_err;
    logic             kbo_overflow;
    logic [FIFO_AW:0] kbo_count;

    int total;
    int bad;
    int err_seen;
    int ovf_seen;
    logic [FIFO_AW:0] cnt_after_stop;

    ps2_keyboard #(.FIFO_AW(FIFO_AW), .TIMEOUT(TMO)) dut (
        .kbi_clk        (kbi_clk),
        .kbi_rst        (kbi_rst),
        .kbi_ps2_clk    (kbi_ps2_clk),
        .kbi_ps2_data   (kbi_ps2_data),
        .kbi_rdn        (kbi_rdn),
        .kbo_data_ready (kbo_data_ready),
        .kbo_scan_code  (kbo_scan_code),
        .kbo_frame_err  (kbo_frame_err),
        .kbo_overflow   (kbo_overflow),
        .kbo_count      (kbo_count)
    );

    initial kbi_clk = 1'b0;
    always #5 kbi_clk = ~kbi_clk;

    // Count every cycle each status pulse is high.
    always @(negedge kbi_clk) begin
        if (kbo_frame_err) err_seen++;
        if (kbo_overflow)  ovf_seen++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // Drive a whole frame; optionally pop on the stop-bit fe cycle.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input logic rd_at_stop);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge kbi_clk);
            kbi_ps2_data = bits[i];
            repeat (10) @(negedge kbi_clk);
            kbi_ps2_clk = 1'b0;
            if (i == 10) begin
                @(negedge kbi_clk);
                @(negedge kbi_clk);
                if (rd_at_stop) kbi_rdn = 1'b0;
                @(negedge kbi_clk);
                cnt_after_stop = kbo_count;
                kbi_rdn = 1'b1;
                repeat (17) @(negedge kbi_clk);
            end else begin
                repeat (20) @(negedge kbi_clk);
            end
            kbi_ps2_clk = 1'b1;
            repeat (9) @(negedge kbi_clk);
        end
        kbi_ps2_data = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, odd_par(d), 1'b1, 1'b0);
    endtask

    // Start bit plus the first n-1 data bits, then leave the bus high.
    task automatic send_partial(input logic [7:0] d, input int n);
        logic [8:0] bits;
        bits = {d, 1'b0};
        for (int i = 0; i < n; i++) begin
            @(negedge kbi_clk);
            kbi_ps2_data = bits[i];
            repeat (10) @(negedge kbi_clk);
            kbi_ps2_clk = 1'b0;
            repeat (20) @(negedge kbi_clk);
            kbi_ps2_clk = 1'b1;
            repeat (9) @(negedge kbi_clk);
        end
        kbi_ps2_data = 1'b1;
    endtask

    task automatic pop_one();
        @(negedge kbi_clk);
        kbi_rdn = 1'b0;
        @(negedge kbi_clk);
        kbi_rdn = 1'b1;
    endtask

    task automatic test_reset();
        kbi_rst      = 1'b1;
        kbi_ps2_clk  = 1'b1;
        kbi_ps2_data = 1'b1;
        kbi_rdn      = 1'b1;
        repeat (3) @(negedge kbi_clk);
        kbi_rst = 1'b0;
        repeat (2) @(negedge kbi_clk);
        total++; if (kbo_data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", kbo_data_ready); end
        total++; if (kbo_scan_code !== 8'h00) begin bad++; $display("FAIL reset_code got=%0h exp=00", kbo_scan_code); end
        total++; if (kbo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", kbo_count); end
        total++; if (kbo_frame_err !== 1'b0 || kbo_overflow !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%0b%0b exp=00", kbo_frame_err, kbo_overflow); end
    endtask

    task automatic test_single();
        send_good(8'h1C);
        total++; if (cnt_after_stop !== 3'd1) begin bad++; $display("FAIL single_count_timing got=%0d exp=1", cnt_after_stop); end
        total++; if (kbo_data_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b exp=1", kbo_data_ready); end
        total++; if (kbo_scan_code !== 8'h1C) begin bad++; $display("FAIL single_code got=%0h exp=1c", kbo_scan_code); end
        pop_one();
        total++; if (kbo_count !== 3'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", kbo_count); end
        total++; if (kbo_data_ready !== 1'b0) begin bad++; $display("FAIL single_pop_ready got=%0b exp=0", kbo_data_ready); end
        // Popping an empty FIFO must be ignored.
        pop_one();
        total++; if (kbo_count !== 3'd0) begin bad++; $display("FAIL empty_pop_count got=%0d exp=0", kbo_count); end
    endtask

    task automatic test_frame_errors();
        int e0;
        e0 = err_seen;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        total++; if (err_seen - e0 !== 2) begin bad++; $display("FAIL frame_err_pulses got=%0d exp=2", err_seen - e0); end
        total++; if (kbo_count !== 3'd0) begin bad++; $display("FAIL frame_err_count got=%0d exp=0", kbo_count); end
    endtask

    task automatic test_overflow();
        int o0;
        int e0;
        logic [7:0] exp_b;
        o0 = ovf_seen;
        e0 = err_seen;
        for (int i = 1; i <= 5; i++) begin
            exp_b = 8'(i);
            send_good(exp_b);
        end
        total++; if (kbo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", kbo_count); end
        total++; if (ovf_seen - o0 !== 1) begin bad++; $display("FAIL ovf_pulses got=%0d exp=1", ovf_seen - o0); end
        total++; if (err_seen - e0 !== 0) begin bad++; $display("FAIL ovf_no_err got=%0d exp=0", err_seen - e0); end
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            total++; if (kbo_scan_code !== exp_b) begin bad++; $display("FAIL ovf_pop_%0d got=%0h exp=%0h", i, kbo_scan_code, exp_b); end
            pop_one();
        end
        total++; if (kbo_data_ready !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0b exp=0", kbo_data_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fill [4];
        logic [7:0] expq [4];
        int o0;
        fill = '{8'h11, 8'h22, 8'h33, 8'h44};
        expq = '{8'h22, 8'h33, 8'h44, 8'hF0};
        for (int i = 0; i < 4; i++) send_good(fill[i]);
        o0 = ovf_seen;
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b1);
        total++; if (ovf_seen - o0 !== 0) begin bad++; $display("FAIL b2b_overflow got=%0d exp=0", ovf_seen - o0); end
        total++; if (cnt_after_stop !== 3'd4) begin bad++; $display("FAIL b2b_count_timing got=%0d exp=4", cnt_after_stop); end
        total++; if (kbo_count !== 3'd4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", kbo_count); end
        for (int i = 0; i < 4; i++) begin
            total++; if (kbo_scan_code !== expq[i]) begin bad++; $display("FAIL b2b_pop_%0d got=%0h exp=%0h", i, kbo_scan_code, expq[i]); end
            pop_one();
        end
        total++; if (kbo_data_ready !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%0b exp=0", kbo_data_ready); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_seen;
        send_partial(8'h07, 4);
        repeat (TMO + 1) @(negedge kbi_clk);
        send_good(8'h5A);
        total++; if (kbo_count !== 3'd1) begin bad++; $display("FAIL tmo_count got=%0d exp=1", kbo_count); end
        total++; if (kbo_scan_code !== 8'h5A) begin bad++; $display("FAIL tmo_code got=%0h exp=5a", kbo_scan_code); end
        total++; if (err_seen - e0 !== 0) begin bad++; $display("FAIL tmo_no_err got=%0d exp=0", err_seen - e0); end
        pop_one();
    endtask

    task automatic test_reset_midframe();
        send_good(8'h12);
        send_good(8'h34);
        total++; if (kbo_count !== 3'd2) begin bad++; $display("FAIL rst_prefill got=%0d exp=2", kbo_count); end
        send_partial(8'h55, 5);
        @(negedge kbi_clk);
        kbi_rst = 1'b1;
        @(negedge kbi_clk);
        kbi_rst = 1'b0;
        total++; if (kbo_data_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%0b exp=0", kbo_data_ready); end
        total++; if (kbo_scan_code !== 8'h00) begin bad++; $display("FAIL rst_mid_code got=%0h exp=00", kbo_scan_code); end
        total++; if (kbo_count !== 3'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", kbo_count); end
        total++; if (kbo_frame_err !== 1'b0 || kbo_overflow !== 1'b0) begin bad++; $display("FAIL rst_mid_pulses got=%0b%0b exp=00", kbo_frame_err, kbo_overflow); end
        send_good(8'h29);
        total++; if (kbo_count !== 3'd1) begin bad++; $display("FAIL rst_after_count got=%0d exp=1", kbo_count); end
        total++; if (kbo_scan_code !== 8'h29) begin bad++; $display("FAIL rst_after_code got=%0h exp=29", kbo_scan_code); end
        pop_one();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        err_seen = 0;
        ovf_seen = 0;
        cnt_after_stop = '0;
        test_reset();
        test_single();
        test_frame_errors();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
